// File: rtl/line_cmd_scheduler.sv
// Command queue and Go/Done sequencer in front of the thick-line engine.
// Commands are buffered in a small circular FIFO and dispatched one at a time, with operands held for the whole draw.
module line_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [8:0]    cmd_x0,
    input  logic [8:0]    cmd_x1,
    input  logic [7:0]    cmd_y0,
    input  logic [7:0]    cmd_y1,
    input  logic [8:0]    cmd_thick,
    input  logic [15:0]   cmd_color,
    input  logic          clear,
    input  logic          irq_en,
    input  logic          irq_ack,
    output logic          eng_go,
    output logic [8:0]    eng_x0,
    output logic [8:0]    eng_x1,
    output logic [7:0]    eng_y0,
    output logic [7:0]    eng_y1,
    output logic [8:0]    eng_thick,
    output logic [15:0]   eng_color,
    input  logic          eng_done,
    output logic          busy,
    output logic [AW:0]   pending,
    output logic          irq,
    output logic [15:0]   lines_drawn
);

    localparam int CW = 59;
    localparam logic [AW:0]   COUNT_ZERO_C = {(AW+1){1'b0}};
    localparam logic [AW:0]   COUNT_ONE_C  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   COUNT_FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE_C    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   LINE_ONE_C   = 16'd1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_next_s;
    logic            push_s;
    logic            pop_s;
    logic            done_s;
    logic            irq_set_s;
    logic [CW-1:0]   cmd_word_s;
    logic [CW-1:0]   head_s;
    logic            eng_go_r;
    logic [CW-1:0]   eng_word_r;
    logic            busy_r;
    logic [AW:0]     pending_r;
    logic            irq_r;
    logic [15:0]     lines_r;

    assign cmd_word_s = {cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_thick, cmd_color};
    assign head_s     = mem_r[rd_ptr_r];
    assign cmd_ready  = (count_r != COUNT_FULL_C) & ~clear;
    assign push_s     = cmd_valid & cmd_ready;

    // Dispatch sequencing: pop a command, pulse Go, then track the engine's Done low/high handshake.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if ((count_r != COUNT_ZERO_C) && !clear) begin
                    pop_s        = 1'b1;
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH: begin
                state_next_s = WAIT_START;
            end
            WAIT_START: begin
                if (!eng_done) begin
                    state_next_s = WAIT_DONE;
                end else begin
                    state_next_s = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    done_s = 1'b1;
                    if ((count_r != COUNT_ZERO_C) && !clear) begin
                        pop_s        = 1'b1;
                        state_next_s = LAUNCH;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Occupancy update; clear wins over everything because it also blocks push and pop.
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = COUNT_ZERO_C;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + COUNT_ONE_C;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - COUNT_ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // A drain is a completion that leaves nothing queued (or everything discarded) with no new arrival.
    always_comb begin
        irq_set_s = 1'b0;
        if (done_s && irq_en && ((count_r == COUNT_ZERO_C) || clear) && !push_s) begin
            irq_set_s = 1'b1;
        end else begin
            irq_set_s = 1'b0;
        end
    end

    // FIFO storage; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_word_s;
        end
    end

    // Control state, FIFO pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= COUNT_ZERO_C;
            eng_go_r   <= 1'b0;
            eng_word_r <= {CW{1'b0}};
            busy_r     <= 1'b0;
            pending_r  <= COUNT_ZERO_C;
            irq_r      <= 1'b0;
            lines_r    <= 16'd0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;

            if (clear) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            // Operands only move on a pop so the engine sees them stable for the whole draw.
            if (pop_s) begin
                eng_word_r <= head_s;
            end else begin
                eng_word_r <= eng_word_r;
            end

            eng_go_r  <= (state_next_s == LAUNCH);
            busy_r    <= (state_next_s != IDLE) || (count_next_s != COUNT_ZERO_C);
            pending_r <= count_next_s;

            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (irq_ack) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end

            if (done_s) begin
                lines_r <= lines_r + LINE_ONE_C;
            end else begin
                lines_r <= lines_r;
            end
        end
    end

    assign eng_go      = eng_go_r;
    assign {eng_x0, eng_x1, eng_y0, eng_y1, eng_thick, eng_color} = eng_word_r;
    assign busy        = busy_r;
    assign pending     = pending_r;
    assign irq         = irq_r;
    assign lines_drawn = lines_r;

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Self-checking bench for line_cmd_scheduler: a queue-based reference model plus a behavioural
// thick-line engine, checked every cycle, with directed scenarios and a randomized phase.
module tb_line_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [8:0]  x0;
        logic [8:0]  x1;
        logic [7:0]  y0;
        logic [7:0]  y1;
        logic [8:0]  thick;
        logic [15:0] color;
    } cmd_t;

    logic        clk = 1'b0;
    logic        resetn, cmd_valid, cmd_ready, clear, irq_en, irq_ack;
    logic [8:0]  cmd_x0, cmd_x1, cmd_thick;
    logic [7:0]  cmd_y0, cmd_y1;
    logic [15:0] cmd_color;
    logic        eng_go, eng_done, busy, irq;
    logic [8:0]  eng_x0, eng_x1, eng_thick;
    logic [7:0]  eng_y0, eng_y1;
    logic [15:0] eng_color, lines_drawn;
    logic [AW:0] pending;

    always #5 clk = ~clk;

    line_cmd_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_thick(cmd_thick), .cmd_color(cmd_color), .clear(clear),
        .irq_en(irq_en), .irq_ack(irq_ack), .eng_go(eng_go),
        .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_y0(eng_y0), .eng_y1(eng_y1),
        .eng_thick(eng_thick), .eng_color(eng_color), .eng_done(eng_done),
        .busy(busy), .pending(pending), .irq(irq), .lines_drawn(lines_drawn)
    );

    // Reference model: queued commands, the command in flight and its handshake phase.
    cmd_t q[$];
    cmd_t cur;
    bit   active, launching, started, irq_m;
    int   lines;
    // Engine model
    bit   go_prev;
    int   eng_cnt, len_lo, len_hi;
    // Bookkeeping
    int   compared, mismatched, irq_rises;
    bit   irq_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int th, input int col);
        cmd_t c;
        c.x0 = 9'(x0); c.y0 = 8'(y0); c.x1 = 9'(x1); c.y1 = 8'(y1);
        c.thick = 9'(th); c.color = 16'(col);
        return c;
    endfunction

    task automatic set_cmd(input cmd_t c);
        {cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_thick, cmd_color} = c;
    endtask

    // One clock cycle: advance the model from the pre-edge inputs, clock, then check and move the engine.
    task automatic tick();
        bit   acc, fin, disp;
        cmd_t c;
        c = {cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_thick, cmd_color};
        if (!resetn) begin
            q.delete();
            active = 0; launching = 0; started = 0; irq_m = 0; lines = 0; cur = '0;
        end else begin
            acc  = cmd_valid && (q.size() < DEPTH) && !clear;
            fin  = active && started && eng_done;
            disp = (!active || fin) && (q.size() != 0) && !clear;
            if (launching) launching = 0;
            else if (active && !started && !eng_done) started = 1;
            else if (fin) begin
                lines  = (lines + 1) % 65536;
                active = 0;
            end
            if (fin && irq_en && (q.size() == 0 || clear) && !acc) irq_m = 1;
            else if (irq_ack) irq_m = 0;
            if (clear) q.delete();
            if (disp) begin
                cur = q.pop_front();
                active = 1; launching = 1; started = 0;
            end
            if (acc) q.push_back(c);
        end

        @(posedge clk);
        #1;
        chk("eng_go",      64'(eng_go), 64'(launching));
        chk("eng_ops",     64'({eng_x0, eng_x1, eng_y0, eng_y1, eng_thick, eng_color}), 64'(cur));
        chk("pending",     64'(pending), 64'(q.size()));
        chk("busy",        64'(busy), 64'(active || q.size() != 0));
        chk("irq",         64'(irq), 64'(irq_m));
        chk("lines_drawn", 64'(lines_drawn), 64'(lines));
        chk("cmd_ready",   64'(cmd_ready), 64'((q.size() < DEPTH) && !clear));
        if (irq === 1'b1 && !irq_prev) irq_rises++;
        irq_prev = (irq === 1'b1);

        if (!resetn) begin
            eng_done = 1'b1; eng_cnt = 0;
        end else if (go_prev) begin
            eng_done = 1'b0; eng_cnt = $urandom_range(len_lo, len_hi);
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_done = 1'b1;
        end
        go_prev = launching;
    endtask

    task automatic push(input cmd_t c);
        int n = 0;
        set_cmd(c);
        cmd_valid = 1'b1;
        while (!((q.size() < DEPTH) && !clear) && n < 200) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
        chk("push_bound", 64'(n < 200), 64'd1);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((active || q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_bound", 64'(n < bound), 64'd1);
    endtask

    initial begin
        int   base;
        cmd_t c;
        logic [63:0] r;
        compared = 0; mismatched = 0; irq_rises = 0; irq_prev = 0;
        active = 0; launching = 0; started = 0; irq_m = 0; lines = 0; cur = '0;
        go_prev = 0; eng_cnt = 0; len_lo = 1; len_hi = 4;
        resetn = 1'b0; cmd_valid = 1'b0; clear = 1'b0; irq_en = 1'b0; irq_ack = 1'b0;
        eng_done = 1'b1;
        set_cmd('0);

        // Reset
        tick(); tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        tick();

        // Single command (0,0)->(10,5), thick 1
        irq_en = 1'b1; len_lo = 3; len_hi = 3;
        push(mk(0, 0, 10, 5, 1, 16'h00AA));
        drain(50);
        chk("t1_lines", 64'(lines_drawn), 64'd1);
        chk("t1_irq", 64'(irq), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_x1", 64'(eng_x1), 64'd10);
        chk("t1_y1", 64'(eng_y1), 64'd5);

        // Five back-to-back pushes into a 4-deep queue
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_rises = 0;
        for (int i = 1; i <= 5; i++) push(mk(i, i, 100 + i, 50 + i, 2, i));
        drain(200);
        chk("t2_lines", 64'(lines_drawn), 64'd6);
        chk("t2_irq_once", 64'(irq_rises), 64'd1);
        chk("t2_last_color", 64'(eng_color), 64'd5);

        // Randomized phase: pushes, acks, enables, occasional clear, random draw lengths
        len_lo = 1; len_hi = 4;
        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom};
            c = r[58:0];
            set_cmd(c);
            cmd_valid = ($urandom_range(0, 1) == 1);
            irq_en    = ($urandom_range(0, 3) != 0);
            irq_ack   = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 31) == 0);
            tick();
        end
        cmd_valid = 1'b0; clear = 1'b0; irq_ack = 1'b0; irq_en = 1'b1;
        drain(200);

        // clear with three queued behind an in-flight draw
        len_lo = 8; len_hi = 8;
        for (int i = 0; i < 4; i++) push(mk(i, 2 * i, 20 + i, 30 + i, 3, 16'h0100 + i));
        for (int i = 0; i < 20 && !(started && q.size() == 3); i++) tick();
        chk("t4_pending_before", 64'(pending), 64'd3);
        base = lines;
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4_pending_after", 64'(pending), 64'd0);
        drain(50);
        chk("t4_lines", 64'(lines_drawn), 64'((base + 1) % 65536));
        chk("t4_color", 64'(eng_color), 64'h0100);

        // irq_ack coinciding with the drain edge: set wins; ack alone later clears
        irq_ack = 1'b1; tick();
        chk("t5_ack_clear", 64'(irq), 64'd0);
        len_lo = 2; len_hi = 2;
        push(mk(1, 2, 3, 4, 5, 16'hBEEF));
        drain(50);
        chk("t5_set_wins", 64'(irq), 64'd1);
        tick();
        chk("t5_ack_alone", 64'(irq), 64'd0);
        irq_ack = 1'b0;

        // resetn during WAIT_DONE with two queued
        len_lo = 8; len_hi = 8;
        for (int i = 0; i < 3; i++) push(mk(7, 7, 8 + i, 9, 1, 16'h0200 + i));
        for (int i = 0; i < 20 && !(started && q.size() == 2); i++) tick();
        chk("t6_pending_before", 64'(pending), 64'd2);
        resetn = 1'b0; tick();
        chk("t6_pending", 64'(pending), 64'd0);
        chk("t6_eng_go", 64'(eng_go), 64'd0);
        chk("t6_lines", 64'(lines_drawn), 64'd0);
        chk("t6_eng_color", 64'(eng_color), 64'd0);
        resetn = 1'b1;
        len_lo = 2; len_hi = 3;
        push(mk(4, 3, 2, 1, 6, 16'h1234));
        drain(50);
        chk("t6_lines_after", 64'(lines_drawn), 64'd1);
        chk("t6_color_after", 64'(eng_color), 64'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
